// File: rtl/defs_pkg.sv
// Shared types for the cpu_ctrl slice: ALU interface, controller states, opcodes.
// No logic, so no latency; no flow control.
// Backpressure: not applicable.
package defs_pkg;

    localparam int INSTR_WIDTH = 16;
    localparam int NUM_REGS    = 8;
    localparam int REG_AW      = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_opcode_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } alu_flags_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_LDI  = 4'h8,
        OP_BZ   = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } ctrl_opcode_t;

    // Opcodes 0x0-0x7 map one-to-one onto the ALU encoding; anything else idles the ALU on ADD.
    function automatic alu_opcode_t map_alu_op(input logic [3:0] opc);
        if (opc[3] == 1'b0) begin
            return alu_opcode_t'(opc[2:0]);
        end
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/regfile.sv
// 8 x WIDTH register file, two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, write visible the cycle after we.
// Backpressure: none, always accepts a write.
module regfile
    import defs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller driving an external ALU and instruction memory.
// Latency: ALU/LDI instruction completes fetch cycles + 2 after its fetch request.
// Backpressure: fetch holds imem_req/imem_addr until imem_ack; HALT stops fetching until reset.
module cpu_ctrl
    import defs_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0]       alu_in1,
    output logic [WIDTH-1:0]       alu_in2,
    output alu_opcode_t            alu_op,
    input  logic [WIDTH-1:0]       alu_out,
    input  alu_flags_t             alu_flags,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    dbg_pc
);

    ctrl_state_t            state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic [WIDTH-1:0]       op1;
    logic [WIDTH-1:0]       op2;
    alu_flags_t             flags_q;
    logic                   req_q;
    logic                   halted_q;

    logic [3:0]          opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [7:0]          imm8;
    logic                is_alu;
    logic                is_ldi;
    logic                rf_we;
    logic [WIDTH-1:0]    rf_wdata;
    logic [WIDTH-1:0]    rf_rdata1;
    logic [WIDTH-1:0]    rf_rdata2;
    logic [PC_WIDTH-1:0] bz_target;

    assign opcode = ir[15:12];
    assign rd     = ir[11:9];
    assign rs1    = ir[8:6];
    assign rs2    = ir[5:3];
    assign imm8   = ir[7:0];

    assign is_alu    = (opcode[3] == 1'b0);
    assign is_ldi    = (opcode == OP_LDI);
    assign rf_we     = (state == EXECUTE) && (is_alu || is_ldi);
    assign rf_wdata  = is_ldi ? WIDTH'(imm8) : alu_out;
    // pc already points past the BZ, so the offset is relative to the next instruction.
    assign bz_target = pc + PC_WIDTH'($signed(imm8));

    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign alu_in1   = op1;
    assign alu_in2   = op2;
    assign alu_op    = map_alu_op(opcode);
    assign halted    = halted_q;
    assign dbg_pc    = pc;

    regfile #(
        .WIDTH (WIDTH)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    // req_q/halted_q are set on the transition into FETCH/HALT so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            op1      <= '0;
            op2      <= '0;
            flags_q  <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        pc    <= pc + PC_WIDTH'(1);
                        state <= DECODE;
                        req_q <= 1'b0;
                    end
                end
                DECODE: begin
                    op1   <= rf_rdata1;
                    op2   <= rf_rdata2;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    if (is_alu) begin
                        flags_q <= alu_flags;
                    end
                    case (opcode)
                        OP_BZ: begin
                            if (flags_q.z) begin
                                pc <= bz_target;
                            end
                        end
                        OP_JMP: begin
                            pc <= PC_WIDTH'(imm8);
                        end
                        OP_HALT: begin
                            state    <= HALT;
                            req_q    <= 1'b0;
                            halted_q <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= IDLE;
                    req_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: behavioural instruction memory with programmable wait states
// and a behavioural 8-bit ALU; expected values are hand-computed per scenario.
module tb_cpu_ctrl;
    import defs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    alu_opcode_t alu_op;
    logic [7:0]  alu_out;
    alu_flags_t  alu_flags;
    logic        halted;
    logic [7:0]  dbg_pc;

    logic [15:0] mem [256];
    int          wait_cfg;
    int          wcnt;
    logic        ack_force;
    int          checks;
    int          failures;

    cpu_ctrl #(
        .WIDTH    (8),
        .PC_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .halted     (halted),
        .dbg_pc     (dbg_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign imem_ack   = ack_force | (imem_req && (wcnt == wait_cfg));

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    always_comb begin
        logic [8:0] s;
        s         = '0;
        alu_out   = '0;
        alu_flags = '0;
        case (alu_op)
            ALU_ADD: begin
                s = {1'b0, alu_in1} + {1'b0, alu_in2};
                alu_out = s[7:0];
                alu_flags.c = s[8];
                alu_flags.v = (alu_in1[7] == alu_in2[7]) && (s[7] != alu_in1[7]);
            end
            ALU_SUB: begin
                s = {1'b0, alu_in1} - {1'b0, alu_in2};
                alu_out = s[7:0];
                alu_flags.c = s[8];
                alu_flags.v = (alu_in1[7] != alu_in2[7]) && (s[7] != alu_in1[7]);
            end
            ALU_AND: alu_out = alu_in1 & alu_in2;
            ALU_OR:  alu_out = alu_in1 | alu_in2;
            ALU_XOR: alu_out = alu_in1 ^ alu_in2;
            ALU_SLL: alu_out = alu_in1 << alu_in2[2:0];
            ALU_SRL: alu_out = alu_in1 >> alu_in2[2:0];
            ALU_SRA: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[2:0]);
            default: alu_out = '0;
        endcase
        alu_flags.z = (alu_out == 8'h00);
        alu_flags.n = alu_out[7];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the next fetch request, returns its address and
    // then waits for the request to drop; ends on a negedge.
    task automatic get_fetch(output logic [7:0] a);
        int n;
        n = 0;
        a = 8'hxx;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: imem_req=%0b, required 1 within 100 cycles", imem_req);
        end else begin
            a = imem_addr;
            while (imem_req && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %0b want 0", halted); end
        checks++;
        if (dbg_pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", dbg_pc); end
        checks++;
        if (alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin
            failures++; $display("FAIL reset_operands: got %h/%h want 00/00", alu_in1, alu_in2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_held_req: got %0b want 0", imem_req); end
    endtask

    task automatic test_alu_chain();
        logic [7:0] a;
        int n;
        clear_mem();
        mem[0] = 16'h827F;  // LDI r1,0x7F
        mem[1] = 16'h8401;  // LDI r2,0x01
        mem[2] = 16'h0650;  // ADD r3,r1,r2
        mem[3] = 16'hF000;  // HALT
        wait_cfg = 0;
        apply_reset();
        get_fetch(a);
        checks++;
        if (a !== 8'h00) begin failures++; $display("FAIL chain_fetch0: got %h want 00", a); end
        get_fetch(a);
        checks++;
        if (a !== 8'h01) begin failures++; $display("FAIL chain_fetch1: got %h want 01", a); end
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin
            failures++; $display("FAIL chain_add_req: got req=%0b addr=%h want 1/02", imem_req, imem_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (alu_op !== ALU_ADD || alu_in1 !== 8'h7F || alu_in2 !== 8'h01) begin
            failures++; $display("FAIL chain_alu_in: got op=%0d %h,%h want 0 7f,01", alu_op, alu_in1, alu_in2);
        end
        checks++;
        if (dut.u_rf.regs[3] !== 8'h00) begin
            failures++; $display("FAIL chain_r3_early: got %h want 00", dut.u_rf.regs[3]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.u_rf.regs[3] !== 8'h80) begin
            failures++; $display("FAIL chain_r3: got %h want 80", dut.u_rf.regs[3]);
        end
        checks++;
        if (dut.flags_q !== 4'b0011) begin
            failures++; $display("FAIL chain_flags zcnv: got %b want 0011", dut.flags_q);
        end
        n = 0;
        while (!halted && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (halted !== 1'b1 || dbg_pc !== 8'h04) begin
            failures++; $display("FAIL chain_halt: got halted=%0b pc=%h want 1/04", halted, dbg_pc);
        end
    endtask

    task automatic test_wait_states();
        clear_mem();
        mem[0] = 16'h8A3C;  // LDI r5,0x3C
        wait_cfg = 3;
        apply_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || dut.ir !== 16'h0000) begin
                failures++;
                $display("FAIL wait_hold%0d: got req=%0b addr=%h ir=%h want 1/00/0000", k, imem_req, imem_addr, dut.ir);
            end
            @(negedge clk);
        end
        checks++;
        if (imem_req !== 1'b0 || dut.ir !== 16'h8A3C || dbg_pc !== 8'h01) begin
            failures++;
            $display("FAIL wait_load: got req=%0b ir=%h pc=%h want 0/8a3c/01", imem_req, dut.ir, dbg_pc);
        end
        wait_cfg = 0;
    endtask

    task automatic test_branch();
        logic [7:0] a;
        // z=1 case: SUB r1,r1,r1 then BZ -2 loops back to 0x04
        clear_mem();
        mem[0] = 16'h8205;  // LDI r1,5
        mem[1] = 16'hA004;  // JMP 0x04
        mem[4] = 16'h1248;  // SUB r1,r1,r1
        mem[5] = 16'h90FE;  // BZ -2
        apply_reset();
        get_fetch(a);
        get_fetch(a);
        get_fetch(a);
        checks++;
        if (a !== 8'h04) begin failures++; $display("FAIL bz_jmp_target: got %h want 04", a); end
        @(negedge clk);
        checks++;
        if (alu_op !== ALU_SUB || alu_in1 !== 8'h05) begin
            failures++; $display("FAIL bz_sub_op: got op=%0d in1=%h want 1/05", alu_op, alu_in1);
        end
        get_fetch(a);
        checks++;
        if (a !== 8'h05) begin failures++; $display("FAIL bz_fetch5: got %h want 05", a); end
        get_fetch(a);
        checks++;
        if (a !== 8'h04) begin failures++; $display("FAIL bz_taken: got %h want 04", a); end
        // z=0 case: OR r2,r1,r1 with r1=5 leaves z clear, branch falls through
        mem[4] = 16'h3448;
        mem[6] = 16'hF000;
        apply_reset();
        get_fetch(a);
        get_fetch(a);
        get_fetch(a);
        @(negedge clk);
        checks++;
        if (alu_op !== ALU_OR) begin failures++; $display("FAIL bz_or_op: got %0d want 3", alu_op); end
        get_fetch(a);
        get_fetch(a);
        checks++;
        if (a !== 8'h06) begin failures++; $display("FAIL bz_not_taken: got %h want 06", a); end
    endtask

    task automatic test_jmp_wrap();
        logic [7:0] a;
        clear_mem();
        mem[0]     = 16'hA0FF;  // JMP 0xFF
        mem[8'hFF] = 16'hB000;  // NOP
        apply_reset();
        get_fetch(a);
        get_fetch(a);
        checks++;
        if (a !== 8'hFF) begin failures++; $display("FAIL jmp_target: got %h want ff", a); end
        checks++;
        if (dbg_pc !== 8'h00) begin failures++; $display("FAIL pc_wrap: got %h want 00", dbg_pc); end
        get_fetch(a);
        checks++;
        if (a !== 8'h00) begin failures++; $display("FAIL wrap_fetch: got %h want 00", a); end
    endtask

    task automatic test_halt();
        logic [7:0] a;
        clear_mem();
        apply_reset();
        get_fetch(a);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1) begin
                failures++; $display("FAIL halt_hold%0d: got req=%0b halted=%0b want 0/1", k, imem_req, halted);
            end
            @(negedge clk);
        end
        apply_reset();
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_cleared: got %0b want 0", halted); end
        get_fetch(a);
        checks++;
        if (a !== 8'h00) begin failures++; $display("FAIL halt_resume: got %h want 00", a); end
    endtask

    task automatic test_reset_midfetch();
        logic [7:0] a;
        clear_mem();
        mem[0] = 16'h8A3C;  // LDI r5,0x3C
        mem[1] = 16'h8C11;  // LDI r6,0x11
        wait_cfg = 0;
        apply_reset();
        get_fetch(a);
        wait_cfg = 5;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
            failures++; $display("FAIL mid_pending: got req=%0b addr=%h want 1/01", imem_req, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dbg_pc !== 8'h00) begin
            failures++; $display("FAIL mid_reset_drop: got req=%0b pc=%h want 0/00", imem_req, dbg_pc);
        end
        ack_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || dbg_pc !== 8'h00 || dut.ir !== 16'h0000) begin
            failures++;
            $display("FAIL mid_late_ack: got req=%0b pc=%h ir=%h want 1/00/0000", imem_req, dbg_pc, dut.ir);
        end
        ack_force = 1'b0;
        wait_cfg  = 0;
        get_fetch(a);
        checks++;
        if (a !== 8'h00 || dut.ir !== 16'h8A3C) begin
            failures++; $display("FAIL mid_resume: got addr=%h ir=%h want 00/8a3c", a, dut.ir);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        wait_cfg  = 0;
        ack_force = 1'b0;
        rst_n     = 1'b0;
        clear_mem();
        test_reset();
        test_alu_chain();
        test_wait_states();
        test_branch();
        test_jmp_wrap();
        test_halt();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath/register width.
REQ-002 SHALL have parameter PC_WIDTH, default 8, program-counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_WIDTH  fetch address.
REQ-007 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  16  instruction word.
REQ-009 SHALL have port alu_in1  output  WIDTH  ALU operand 1.
REQ-010 SHALL have port alu_in2  output  WIDTH  ALU operand 2.
REQ-011 SHALL have port alu_op  output  alu_opcode_t  ALU operation.
REQ-012 SHALL have port alu_out  input  WIDTH  ALU result.
REQ-013 SHALL have port alu_flags  input  alu_flags_t  ALU flags (z, c, n, v).
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port dbg_pc  output  PC_WIDTH  current PC.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, HALT; IDLE->FETCH unconditionally one cycle after reset release.
REQ-017 SHALL in FETCH drive imem_req=1, imem_addr=pc, both stable until imem_ack sampled high; imem_req=0 in all other states.
REQ-018 SHALL on the FETCH cycle with imem_ack=1 load ir<=imem_rdata, pc<=pc+1 (modulo 2^PC_WIDTH, 0xFF->0x00), go DECODE; ack in the same cycle as req is legal (zero wait states).
REQ-019 SHALL ignore imem_ack outside FETCH.
REQ-020 SHALL decode ir: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8.
REQ-021 SHALL in DECODE register op1<=R[rs1], op2<=R[rs2], go EXECUTE.
REQ-022 SHALL drive alu_in1=op1, alu_in2=op2 always; alu_op = mapped operation for opcodes 0x0-0x7 (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA in that order), else ALU_ADD.
REQ-023 SHALL in EXECUTE for opcodes 0x0-0x7 write R[rd]<=alu_out and flags_q<=alu_flags at the clock edge ending EXECUTE.
REQ-024 SHALL for 0x8 LDI write R[rd]<=imm8 (zero-extended), flags_q unchanged.
REQ-025 SHALL for 0x9 BZ set pc<=pc+sext(imm8) (pc already incremented) iff flags_q.z=1, modulo 2^PC_WIDTH.
REQ-026 SHALL for 0xA JMP set pc<=imm8.
REQ-027 SHALL for 0xF HALT enter HALT; HALT is left only by reset.
REQ-028 SHALL treat opcodes 0xB-0xE as NOP.
REQ-029 SHALL leave EXECUTE for FETCH (except HALT); ALU/LDI instruction latency = fetch cycles + 2.
REQ-030 SHALL read registers written by the previous instruction correctly (write completes before next DECODE; no forwarding needed).
REQ-031 SHALL drive halted=(state==HALT), dbg_pc=pc.

Reset
REQ-032 SHALL on rst_n=0 asynchronously set state=IDLE, pc=0, ir=0, op1=op2=0, flags_q=0, all eight registers=0.
REQ-033 SHALL thereby drop imem_req to 0 immediately, including mid-fetch with wait states pending; a late imem_ack after reset is ignored.

Structure
REQ-034 SHALL place ctrl_state_t, ctrl_opcode_t and INSTR_WIDTH=16 in defs_pkg alongside alu_opcode_t and alu_flags_t.
REQ-035 SHALL instantiate one sub-module regfile (8 x WIDTH, two combinational read ports, one synchronous write port, same clk/rst_n).

Verification
REQ-036 SHALL cover: LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2, zero wait -> r3=0x80, flags_q n=1 v=1 z=0, ADD done 3 cycles after its imem_req.
REQ-037 SHALL cover: imem_ack delayed 3 cycles -> imem_req/imem_addr stable 4 cycles, ir loaded only on ack cycle.
REQ-038 SHALL cover: SUB r1,r1,r1 then BZ imm8=0xFE at addr 0x05 -> next fetch addr 0x04; with z=0 -> 0x06.
REQ-039 SHALL cover: JMP 0xFF, NOP at 0xFF -> following fetch addr 0x00.
REQ-040 SHALL cover: HALT -> halted=1, imem_req stays 0 for 20 cycles; reset -> fetch resumes at 0x00.
REQ-041 SHALL cover: rst_n low during wait-state fetch -> imem_req=0 same cycle, dbg_pc=0, later ack ignored.
